game_ctrl: RTL

Top-level game sequencer for the flappy-ghost design. It owns the one-hot `state[2:0]` bus that the pixel display mux consumes (ready / playing / ending), converts the raw jump button into per-frame flap pulses, and latches pixel-rate collision hits into a per-frame game-over decision. It also keeps the current and best score in two-digit BCD for the overlay. It sits between the VGA timing generator (`frame_tick`), the bird/pillar position logic (`flap`, `game_rst`, `pass`) and `display`.

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_bcd_counter2.sv | 41 ++++
 rtl/game_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the flappy-ghost game: one-hot play states and BCD score layout.
// Imported by game_ctrl, its score counter and the display mux.
package game_pkg;

    localparam int DIGIT_W = 4;
    localparam int SCORE_W = 2 * DIGIT_W;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;

    typedef enum logic [2:0] {
        ST_READY = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    // Tens digit dominates; ones only break a tie.
    function automatic logic bcd_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic [DIGIT_W-1:0] a_tens, a_ones, b_tens, b_ones;
        a_tens = a[SCORE_W-1:DIGIT_W];
        a_ones = a[DIGIT_W-1:0];
        b_tens = b[SCORE_W-1:DIGIT_W];
        b_ones = b[DIGIT_W-1:0];
        return (a_tens > b_tens) || ((a_tens == b_tens) && (a_ones > b_ones));
    endfunction

endpackage

// File: rtl/game_bcd_counter2.sv
// Two-digit BCD counter with clear and increment, saturating at 99; clear wins over increment.
// Registered count updates one cycle after inc/clr; count_next exposes the value being loaded.
module bcd_counter2
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] count,
    output logic [SCORE_W-1:0] count_next
);

    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;

    assign tens = count[SCORE_W-1:DIGIT_W];
    assign ones = count[DIGIT_W-1:0];

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count != SCORE_MAX)) begin
            if (ones == DIGIT_W'(9)) begin
                count_next = {tens + DIGIT_W'(1), {DIGIT_W{1'b0}}};
            end else begin
                count_next = {tens, ones + DIGIT_W'(1)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: one-hot READY/PLAYING/ENDING, frame-rate flap pulses, hit latch, BCD score/best.
// state/flap/game_rst change one cycle after frame_tick; score one cycle after pass.
module game_ctrl
    import game_pkg::*;
#(
    parameter int END_HOLD = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn,
    input  logic       hit,
    input  logic       pass,
    output logic [2:0] state,
    output logic       flap,
    output logic       game_rst,
    output logic [7:0] score,
    output logic [7:0] best
);

    localparam logic [7:0] HOLD_MAX = 8'(END_HOLD);

    logic       btn_meta;
    logic       btn_s;
    logic       btn_prev;
    logic       hit_lat;
    logic [7:0] hold_cnt;
    logic [2:0] state_q;

    logic       playing;
    logic       press;
    logic       hit_now;
    logic       start;
    logic       score_inc;
    logic [7:0] score_next;

    assign playing   = (state_q == ST_PLAY);
    assign press     = frame_tick & btn_s & ~btn_prev;
    // A hit in the tick cycle itself belongs to the frame being judged.
    assign hit_now   = hit_lat | hit;
    assign start     = (state_q == ST_READY) & press;
    assign score_inc = pass & playing;

    bcd_counter2 u_score (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (score_inc),
        .clr        (start),
        .count      (score),
        .count_next (score_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            btn_prev <= 1'b0;
            hit_lat  <= 1'b0;
            hold_cnt <= '0;
            state_q  <= ST_READY;
            flap     <= 1'b0;
            game_rst <= 1'b0;
            best     <= '0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
            flap     <= 1'b0;
            game_rst <= 1'b0;

            if (frame_tick) begin
                btn_prev <= btn_s;
            end

            if (frame_tick) begin
                hit_lat <= 1'b0;
            end else if (playing && hit) begin
                hit_lat <= 1'b1;
            end

            case (state_q)
                ST_READY: begin
                    if (press) begin
                        state_q  <= ST_PLAY;
                        game_rst <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        if (hit_now) begin
                            state_q  <= ST_END;
                            hold_cnt <= '0;
                            if (bcd_gt(score_next, best)) begin
                                best <= score_next;
                            end
                        end else if (press) begin
                            flap <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (frame_tick) begin
                        if ((hold_cnt == HOLD_MAX) && press) begin
                            state_q  <= ST_READY;
                            game_rst <= 1'b1;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
